bmu_soft_pipe: RTL and testbench

- Parametrised, pipelined branch-metric unit for rate-1/CODE_N Viterbi decoding.
- Replaces the fixed 2-bit hard-decision per-state BMC cells.
- Takes one received symbol (CODE_N soft samples plus per-bit erasure flags) per handshake and emits all 2^CODE_N branch metrics at once, min-normalised, for the ACS array.
- Supports a hard-decision mode (Hamming) and depuncturing via erasures; sits between the depuncturer/receive FIFO and the ACS bank.

---
 rtl/bmu_pkg.sv | 18 +
 rtl/bmu_bit_dist.sv | 23 ++
 rtl/bmu_soft_pipe.sv | 115 +++++++++++
 tb/tb_bmu_soft_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmu_pkg.sv
// Shared constants and helpers for the soft-decision branch-metric unit.
package bmu_pkg;

   localparam int unsigned CODE_N_MIN = 2;
   localparam int unsigned CODE_N_MAX = 4;
   localparam int unsigned SOFT_W_MIN = 1;
   localparam int unsigned SOFT_W_MAX = 6;

   // Width that holds the largest possible metric: every bit at full distance.
   function automatic int unsigned bm_width(input int unsigned code_n, input int unsigned soft_w);
      return $clog2(code_n * ((32'd1 << soft_w) - 32'd1) + 32'd1);
   endfunction

   function automatic logic cw_bit(input int unsigned cw, input int unsigned j);
      return 1'((cw >> j) & 32'd1);
   endfunction

endpackage

// File: rtl/bmu_bit_dist.sv
// Distance of one received sample from one expected code bit (soft, hard or erased).
module bmu_bit_dist #(
   parameter int unsigned SOFT_W = 3
) (
   input  logic [SOFT_W-1:0] sample,
   input  logic              erase,
   input  logic              hard,
   input  logic              exp_bit,
   output logic [SOFT_W-1:0] dist_c
);

   localparam logic [SOFT_W-1:0] S_MAX = '1;

   always_comb begin
      dist_c = '0;
      if (!erase) begin
         if (hard)         dist_c = SOFT_W'(sample[SOFT_W-1] ^ exp_bit);
         else if (exp_bit) dist_c = S_MAX - sample;
         else              dist_c = sample;
      end
   end

endmodule

// File: rtl/bmu_soft_pipe.sv
// Two-stage branch-metric unit: S1 sums per-bit distances, S2 min-normalises for the ACS bank.
module bmu_soft_pipe
   import bmu_pkg::*;
#(
   parameter  int unsigned CODE_N  = 2,
   parameter  int unsigned SOFT_W  = 3,
   parameter  int unsigned NORM_EN = 1,
   localparam int unsigned BM_W    = bm_width(CODE_N, SOFT_W),
   localparam int unsigned NCW     = 32'd1 << CODE_N
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_N*SOFT_W-1:0] in_sym,
   input  logic [CODE_N-1:0]        in_erase,
   input  logic                     in_hard,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NCW*BM_W-1:0]      out_bm,
   output logic                     out_last,
   output logic [15:0]              out_sym_cnt
);

   if (CODE_N < CODE_N_MIN || CODE_N > CODE_N_MAX ||
       SOFT_W < SOFT_W_MIN || SOFT_W > SOFT_W_MAX) begin : g_bad_param
      $error("bmu_soft_pipe: CODE_N or SOFT_W out of range");
   end

   logic [SOFT_W-1:0] dist_c [NCW][CODE_N];
   logic [BM_W-1:0]   raw_bm [NCW];
   logic [BM_W-1:0]   s1_bm  [NCW];
   logic              s1_valid;
   logic              s1_last;
   logic [BM_W-1:0]   min_bm;
   logic [NCW*BM_W-1:0] norm_bm;
   logic              s2_load;
   logic              in_fire;
   logic              out_fire;

   // One distance cell per (expected codeword, code bit) pair.
   for (genvar i = 0; i < NCW; i++) begin : g_cw
      for (genvar j = 0; j < CODE_N; j++) begin : g_bit
         bmu_bit_dist #(.SOFT_W(SOFT_W)) u_dist (
            .sample  (in_sym[j*SOFT_W +: SOFT_W]),
            .erase   (in_erase[j]),
            .hard    (in_hard),
            .exp_bit (cw_bit(i, j)),
            .dist_c  (dist_c[i][j])
         );
      end
   end

   always_comb begin
      for (int i = 0; i < NCW; i++) begin
         raw_bm[i] = '0;
         for (int j = 0; j < CODE_N; j++) begin
            raw_bm[i] = raw_bm[i] + BM_W'(dist_c[i][j]);
         end
      end
   end

   // Minimum search and subtraction on the S1 contents feeding S2.
   always_comb begin
      min_bm = s1_bm[0];
      for (int i = 1; i < NCW; i++) begin
         if (s1_bm[i] < min_bm) min_bm = s1_bm[i];
      end
      norm_bm = '0;
      for (int i = 0; i < NCW; i++) begin
         norm_bm[i*BM_W +: BM_W] = (NORM_EN != 0) ? s1_bm[i] - min_bm : s1_bm[i];
      end
   end

   assign out_fire = out_valid & out_ready;
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~rst & (~s1_valid | s2_load);
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_last     <= 1'b0;
         s1_bm       <= '{default: '0};
         out_valid   <= 1'b0;
         out_bm      <= '0;
         out_last    <= 1'b0;
         out_sym_cnt <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_bm    <= raw_bm;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_load) begin
            out_valid <= 1'b1;
            out_bm    <= norm_bm;
            out_last  <= s1_last;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         // Counter tags the symbol on the output; the transfer of a last symbol rearms it.
         if (out_fire) begin
            if (out_last)                     out_sym_cnt <= '0;
            else if (out_sym_cnt != 16'hFFFF) out_sym_cnt <= out_sym_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bmu_soft_pipe.sv
// Directed and randomised checks of bmu_soft_pipe against a scoreboard of modelled metrics.
module tb_bmu_soft_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [5:0]  in_sym = '0;
   logic [1:0]  in_erase = '0;
   logic        in_hard = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_last;
   logic [15:0] out_bm, out_sym_cnt;
   logic        n_in_ready, n_out_valid, n_out_last;
   logic [15:0] n_out_bm, n_out_sym_cnt;

   always #5 clk = ~clk;

   bmu_soft_pipe #(.CODE_N(2), .SOFT_W(3), .NORM_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
      .in_erase(in_erase), .in_hard(in_hard), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_bm(out_bm), .out_last(out_last), .out_sym_cnt(out_sym_cnt)
   );

   bmu_soft_pipe #(.CODE_N(2), .SOFT_W(3), .NORM_EN(0)) dut_raw (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_sym(in_sym),
      .in_erase(in_erase), .in_hard(in_hard), .in_last(in_last), .out_valid(n_out_valid),
      .out_ready(out_ready), .out_bm(n_out_bm), .out_last(n_out_last), .out_sym_cnt(n_out_sym_cnt)
   );

   typedef struct {
      logic [15:0] bm;
      logic [15:0] raw;
      logic        last;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_err = 0;
   int          n_chk = 0;
   int          n_in = 0;
   int          n_out = 0;
   logic [15:0] exp_cnt = '0;
   logic        held = 1'b0;
   logic [15:0] held_bm, held_cnt;
   logic        held_last;

   function automatic logic [15:0] model(input logic [5:0] sym, input logic [1:0] er,
                                         input logic hard, input bit norm);
      logic [3:0]  m [4];
      logic [3:0]  mn, d;
      logic [2:0]  s;
      logic        e;
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         m[i] = '0;
         for (int j = 0; j < 2; j++) begin
            s = sym[j*3 +: 3];
            e = ((i >> j) & 1) != 0;
            if (er[j])     d = 4'd0;
            else if (hard) d = {3'b000, s[2] ^ e};
            else if (e)    d = 4'd7 - {1'b0, s};
            else           d = {1'b0, s};
            m[i] = m[i] + d;
         end
      end
      mn = m[0];
      for (int i = 1; i < 4; i++) if (m[i] < mn) mn = m[i];
      r = '0;
      for (int i = 0; i < 4; i++) r[i*4 +: 4] = norm ? m[i] - mn : m[i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [5:0] sym, input logic [1:0] er, input logic hard, input logic last);
      exp_t e;
      bit   done = 0;
      in_sym = sym; in_erase = er; in_hard = hard; in_last = last; in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            e.bm = model(sym, er, hard, 1); e.raw = model(sym, er, hard, 0);
            e.last = last; e.cnt = exp_cnt;
            sb.push_back(e);
            exp_cnt = last ? 16'd0 : exp_cnt + 16'd1;
            n_in++;
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_chk++; n_err++;
         $error("FAIL send_timeout: in_ready observed=0 expected=1 within 50 cycles");
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && sb.size() != 0; k++) @(posedge clk);
      #1;
      check("drain_empty", sb.size(), 0);
   endtask

   // Output monitor: pops the scoreboard on each transfer and checks hold stability under stall.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (out_valid) begin
         if (held) begin
            check("hold_bm", out_bm, held_bm);
            check("hold_last", out_last, held_last);
            check("hold_cnt", out_sym_cnt, held_cnt);
         end
         if (out_ready) begin
            n_chk++;
            assert (sb.size() != 0) else begin
               n_err++;
               $error("FAIL extra_output: observed bm=%0h expected no output", out_bm);
            end
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("out_bm", out_bm, mon_e.bm);
               check("out_last", out_last, mon_e.last);
               check("out_sym_cnt", out_sym_cnt, mon_e.cnt);
               check("raw_valid", n_out_valid, 1);
               check("raw_bm", n_out_bm, mon_e.raw);
               check("raw_last", n_out_last, mon_e.last);
               check("raw_cnt", n_out_sym_cnt, mon_e.cnt);
               n_out++;
            end
         end
         held = !out_ready;
         held_bm = out_bm; held_last = out_last; held_cnt = out_sym_cnt;
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      // Reset state
      @(negedge clk);
      check("in_ready_in_reset", in_ready, 0);
      @(posedge clk); @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_bm", out_bm, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_cnt", out_sym_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_raw_ready", n_in_ready, 1);

      // Two-cycle latency on a strong symbol
      @(posedge clk); #1;
      send(6'b111_000, 2'b00, 1'b0, 1'b1);
      @(negedge clk);
      check("lat1_valid", out_valid, 0);
      @(negedge clk);
      check("lat2_valid", out_valid, 1);
      check("lat2_bm", out_bm, 16'h70E7);
      check("lat2_last", out_last, 1);
      @(posedge clk); #1;

      // Soft, hard, partial erase, full erase
      send(6'b100_011, 2'b00, 1'b0, 1'b0);
      send(6'b100_011, 2'b00, 1'b1, 1'b0);
      send(6'b111_111, 2'b10, 1'b0, 1'b0);
      send(6'b101_010, 2'b11, 1'b1, 1'b1);
      drain();

      // Random symbols with random output stalls
      fork
         begin
            for (int k = 0; k < 10; k++)
               send(6'($urandom), 2'($urandom), 1'($urandom), k == 9);
         end
         begin
            repeat (40) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
      check("cnt_after_block", out_sym_cnt, 0);

      // Backpressure: four back-to-back symbols, output stalled for three edges
      @(posedge clk); #1; out_ready = 1'b0;
      fork
         begin
            send(6'b001_110, 2'b00, 1'b0, 1'b0);
            send(6'b110_001, 2'b01, 1'b0, 1'b0);
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
            send(6'b011_101, 2'b00, 1'b1, 1'b0);
            send(6'b000_111, 2'b00, 1'b0, 1'b1);
         end
         begin
            repeat (3) @(posedge clk);
            #1; out_ready = 1'b1;
         end
      join
      drain();
      check("bp_cnt_wrap", out_sym_cnt, 0);

      // Reset with two symbols in flight mid-block
      send(6'b010_010, 2'b00, 1'b0, 1'b0);
      drain();
      check("cnt_mid_block", out_sym_cnt, 1);
      out_ready = 1'b0;
      send(6'b111_000, 2'b00, 1'b0, 1'b0);
      send(6'b000_111, 2'b00, 1'b0, 1'b0);
      rst = 1'b1;
      n_in = n_in - sb.size();
      sb.delete();
      exp_cnt = '0;
      @(negedge clk);
      check("in_ready_rst_pulse", in_ready, 0);
      @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_cnt", out_sym_cnt, 0);
      @(posedge clk); #1;
      send(6'b100_011, 2'b00, 1'b0, 1'b1);
      drain();

      check("in_out_count", n_out, n_in);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
